// File: rtl/led_bar_pkg.sv
// Shared types and encodings for the LED bar animator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package led_bar_pkg;

  localparam logic [1:0] MODE_FILL_ENC      = 2'd0;
  localparam logic [1:0] MODE_DRAIN_ENC     = 2'd1;
  localparam logic [1:0] MODE_BOUNCE_ENC    = 2'd2;
  localparam logic [1:0] MODE_FILL_WRAP_ENC = 2'd3;

  typedef enum logic [1:0] {
    FILL      = MODE_FILL_ENC,
    DRAIN     = MODE_DRAIN_ENC,
    BOUNCE    = MODE_BOUNCE_ENC,
    FILL_WRAP = MODE_FILL_WRAP_ENC
  } led_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } led_state_t;

endpackage

// File: rtl/led_bar_animator_if.sv
// Control/status bundle between the board button logic and the animator.
// Latency: n/a (wiring only).
// Backpressure: none; button is level-sampled, status outputs are registered.
interface led_bar_animator_if #(
  parameter int LED_W = 16,
  parameter int DIV_W = 8
);
  logic             button;
  logic [1:0]       mode;
  logic [DIV_W-1:0] rate;
  logic [LED_W-1:0] led;
  logic             busy;
  logic             paused;
  logic             done;

  modport master (output button, mode, rate, input led, busy, paused, done);
  modport slave  (input button, mode, rate, output led, busy, paused, done);
endinterface

// File: rtl/led_bar_prescaler.sv
// Step-rate prescaler: one tick every rate+1 enabled cycles.
// Latency: tick is combinational from the held count and live rate.
// Backpressure: count holds while en is low; clr returns it to zero.
module led_bar_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] rate,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = en && (cnt == rate);

  // Count 0..rate while enabled; a lowered rate lets the count wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= tick ? '0 : cnt + DIV_W'(1);
  end

endmodule

// File: rtl/led_bar_animator.sv
// LED bar pattern engine (fill/drain/bounce/fill-wrap) with button start/pause/resume.
// Latency: button edge acts on the next clk edge (+2 cycles with LED_BAR_BTN_SYNC_EN).
// Backpressure: none; PAUSE freezes pattern and prescaler count.
module led_bar_animator
  import led_bar_pkg::*;
#(
  parameter int LED_W = 16,
  parameter int DIV_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  led_bar_animator_if.slave   bus
);

  localparam int LVL_W = $clog2(LED_W + 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LED_W);
  localparam logic [LVL_W-1:0] POS_MAX = LVL_W'(LED_W - 1);

  function automatic logic [LED_W-1:0] low_ones(input logic [LVL_W-1:0] n);
    logic [LED_W-1:0] r;
    r = '0;
    for (int i = 0; i < LED_W; i++) r[i] = (LVL_W'(i) < n);
    return r;
  endfunction

  function automatic logic [LED_W-1:0] one_hot(input logic [LVL_W-1:0] p);
    logic [LED_W-1:0] r;
    r = '0;
    for (int i = 0; i < LED_W; i++) r[i] = (LVL_W'(i) == p);
    return r;
  endfunction

  logic btn_in, button_q, btn_edge;

`ifdef LED_BAR_BTN_SYNC_EN
  logic [1:0] btn_sync;
  // Two-flop synchroniser for an asynchronous push button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_sync <= '0;
    else     btn_sync <= {btn_sync[0], bus.button};
  end
  assign btn_in = btn_sync[1];
`else
  assign btn_in = bus.button;
`endif

  // Previous button level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) button_q <= 1'b0;
    else     button_q <= btn_in;
  end
  assign btn_edge = btn_in & ~button_q;

  led_state_t       state_q, state_d;
  led_mode_t        mode_q, mode_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [LVL_W-1:0] lvl_q, lvl_d, lvl_inc;
  logic [LVL_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             busy_q, paused_q, done_q;
  logic             pre_en, pre_clr, tick;

  // A button edge in RUN pauses; the prescaler holds on that cycle so no step is lost.
  assign pre_en = (state_q == RUN) && !btn_edge;

  led_bar_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .rate (bus.rate),
    .tick (tick)
  );

  // Next state, next pattern and start-up loading.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    led_d   = led_q;
    lvl_d   = lvl_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    pre_clr = 1'b0;
    lvl_inc = lvl_q + LVL_W'(1);
    case (state_q)
      IDLE, DONE: begin
        if (btn_edge) begin
          state_d = RUN;
          mode_d  = led_mode_t'(bus.mode);
          pre_clr = 1'b1;
          lvl_d   = '0;
          pos_d   = '0;
          dir_d   = 1'b0;
          case (led_mode_t'(bus.mode))
            DRAIN:   led_d = '1;
            BOUNCE:  led_d = LED_W'(1);
            default: led_d = '0;
          endcase
        end
      end
      RUN: begin
        if (btn_edge) begin
          state_d = PAUSE;
        end else if (tick) begin
          case (mode_q)
            FILL, DRAIN: begin
              lvl_d = lvl_inc;
              led_d = (mode_q == FILL) ? low_ones(lvl_inc) : low_ones(LVL_MAX - lvl_inc);
              if (lvl_inc == LVL_MAX) state_d = DONE;
            end
            FILL_WRAP: begin
              if (lvl_q == LVL_MAX) begin
                lvl_d = '0;
                led_d = '0;
              end else begin
                lvl_d = lvl_inc;
                led_d = low_ones(lvl_inc);
              end
            end
            default: begin
              // BOUNCE: reverse at either end without lingering on the end bit.
              if (!dir_q) begin
                if (pos_q == POS_MAX) begin
                  dir_d = 1'b1;
                  pos_d = pos_q - LVL_W'(1);
                end else begin
                  pos_d = pos_q + LVL_W'(1);
                end
              end else begin
                if (pos_q == '0) begin
                  dir_d = 1'b0;
                  pos_d = LVL_W'(1);
                end else begin
                  pos_d = pos_q - LVL_W'(1);
                end
              end
              led_d = one_hot(pos_d);
            end
          endcase
        end
      end
      default: begin
        if (btn_edge) state_d = RUN;
      end
    endcase
  end

  // State, pattern and status registers; status follows the next state directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= FILL;
      led_q    <= '0;
      lvl_q    <= '0;
      pos_q    <= '0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      led_q    <= led_d;
      lvl_q    <= lvl_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      busy_q   <= (state_d == RUN) || (state_d == PAUSE);
      paused_q <= (state_d == PAUSE);
      done_q   <= (state_d == DONE);
    end
  end

  assign bus.led    = led_q;
  assign bus.busy   = busy_q;
  assign bus.paused = paused_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_led_bar_animator.sv
// Self-checking bench for led_bar_animator (LED_W=16, no button synchroniser).
// Latency: inputs driven at negedge, outputs sampled 1 time unit after posedge.
// Backpressure: n/a.
module tb_led_bar_animator;
  import led_bar_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  led_bar_animator_if #(.LED_W(16), .DIV_W(8)) bus ();

  led_bar_animator #(.LED_W(16), .DIV_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: phase 0 idle, 1 run, 2 pause, 3 done; k = steps taken since start.
  int m_phase, m_k, m_cnt, m_mode;
  logic m_bq;

  function automatic logic [15:0] pattern(input int md, input int k);
    logic [31:0] v;
    int p;
    case (md)
      0: v = (32'h1 << ((k > 16) ? 16 : k)) - 32'h1;
      1: v = 32'hFFFF >> k;
      2: begin
        p = k % 30;
        v = 32'h1 << ((p <= 15) ? p : 30 - p);
      end
      default: v = (32'h1 << (k % 17)) - 32'h1;
    endcase
    return v[15:0];
  endfunction

  function automatic logic [18:0] exp_out();
    logic [15:0] l;
    l = (m_phase == 0) ? 16'h0 : pattern(m_mode, m_k);
    return {l, (m_phase == 1 || m_phase == 2), (m_phase == 2), (m_phase == 3)};
  endfunction

  function automatic logic [18:0] dut_out();
    return {bus.led, bus.busy, bus.paused, bus.done};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_k = 0; m_cnt = 0; m_mode = 0; m_bq = 1'b0;
  endtask

  task automatic model_clock(input logic b, input logic [1:0] m, input logic [7:0] r);
    logic e;
    e = b && !m_bq;
    m_bq = b;
    case (m_phase)
      0, 3: if (e) begin m_phase = 1; m_mode = int'(m); m_k = 0; m_cnt = 0; end
      1: begin
        if (e) m_phase = 2;
        else if (m_cnt == int'(r)) begin
          m_cnt = 0;
          m_k++;
          if (m_mode <= 1 && m_k == 16) m_phase = 3;
        end else m_cnt = (m_cnt + 1) % 256;
      end
      default: if (e) m_phase = 1;
    endcase
  endtask

  task automatic step(input logic b, input logic [1:0] m, input logic [7:0] r);
    @(negedge clk);
    bus.button = b; bus.mode = m; bus.rate = r;
    model_clock(b, m, r);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.button = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.button = 1'b0; bus.mode = 2'd0; bus.rate = 8'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 2'd0, 8'd0);
      checks++;
      if (dut_out() !== 19'h0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got %h want 00000", i, dut_out());
      end
    end
  endtask

  task automatic test_fill();
    step(1'b1, 2'd0, 8'd0);
    checks++;
    if (dut_out() !== {16'h0000, 3'b100}) begin
      errors++; $display("FAIL fill_start got %h want %h", dut_out(), {16'h0000, 3'b100});
    end
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 2'd0, 8'd0);
      checks++;
      if (dut_out() !== exp_out()) begin
        errors++; $display("FAIL fill_model step=%0d got %h want %h", i, dut_out(), exp_out());
      end
      if (i == 1 || i == 2) begin
        checks++;
        if (bus.led !== ((i == 1) ? 16'h0001 : 16'h0003)) begin
          errors++; $display("FAIL fill_early step=%0d got %h", i, bus.led);
        end
      end
      if (i >= 16) begin
        checks++;
        if (bus.led !== 16'hFFFF || bus.done !== 1'b1) begin
          errors++; $display("FAIL fill_done step=%0d got led=%h done=%b want FFFF 1", i, bus.led, bus.done);
        end
      end
    end
  endtask

  task automatic test_drain();
    step(1'b1, 2'd1, 8'd3);
    for (int i = 1; i <= 70; i++) begin
      step(1'b0, 2'd1, 8'd3);
      checks++;
      if (dut_out() !== exp_out()) begin
        errors++; $display("FAIL drain_model step=%0d got %h want %h", i, dut_out(), exp_out());
      end
      if (i == 4 || i == 8 || i == 64) begin
        checks++;
        if (bus.led !== ((i == 4) ? 16'h7FFF : (i == 8) ? 16'h3FFF : 16'h0000) || bus.done !== (i == 64)) begin
          errors++; $display("FAIL drain_point step=%0d got led=%h done=%b", i, bus.led, bus.done);
        end
      end
    end
  endtask

  task automatic test_bounce();
    step(1'b1, 2'd2, 8'd0);
    for (int i = 1; i <= 200; i++) begin
      step(1'b0, 2'd2, 8'd0);
      checks++;
      if (dut_out() !== exp_out() || bus.done !== 1'b0) begin
        errors++; $display("FAIL bounce_model step=%0d got %h want %h", i, dut_out(), exp_out());
      end
      if (i == 15 || i == 16 || i == 30) begin
        checks++;
        if (bus.led !== ((i == 15) ? 16'h8000 : (i == 16) ? 16'h4000 : 16'h0001)) begin
          errors++; $display("FAIL bounce_point step=%0d got %h", i, bus.led);
        end
      end
    end
  endtask

  task automatic test_pause_resume();
    do_reset();
    step(1'b1, 2'd0, 8'd0);
    for (int i = 1; i <= 8; i++) step(1'b0, 2'd0, 8'd0);
    checks++;
    if (bus.led !== 16'h00FF) begin
      errors++; $display("FAIL pause_pre got %h want 00FF", bus.led);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 2'd0, 8'd0);
      checks++;
      if (bus.led !== 16'h00FF || bus.paused !== 1'b1 || dut_out() !== exp_out()) begin
        errors++; $display("FAIL pause_hold cyc=%0d got %h want 00FF paused", i, dut_out());
      end
    end
    step(1'b0, 2'd0, 8'd0);
    step(1'b1, 2'd0, 8'd0);
    checks++;
    if (bus.led !== 16'h00FF || bus.paused !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL resume_edge got %h", dut_out());
    end
    step(1'b1, 2'd0, 8'd0);
    checks++;
    if (bus.led !== 16'h01FF || dut_out() !== exp_out()) begin
      errors++; $display("FAIL resume_step got %h want 01FF", bus.led);
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    step(1'b1, 2'd3, 8'd0);
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, (i > 5) ? 2'd1 : 2'd3, 8'd0);
      checks++;
      if (dut_out() !== exp_out()) begin
        errors++; $display("FAIL wrap_model step=%0d got %h want %h", i, dut_out(), exp_out());
      end
      if (i >= 16 && i <= 18) begin
        checks++;
        if (bus.led !== ((i == 16) ? 16'hFFFF : (i == 17) ? 16'h0000 : 16'h0001) || bus.done !== 1'b0) begin
          errors++; $display("FAIL wrap_point step=%0d got led=%h done=%b", i, bus.led, bus.done);
        end
      end
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.led !== 16'h0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL async_reset got led=%h busy=%b want 0000 0", bus.led, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd0, 8'd0);
      checks++;
      if (dut_out() !== exp_out()) begin
        errors++; $display("FAIL post_reset cyc=%0d got %h want %h", i, dut_out(), exp_out());
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic [1:0] m;
    logic b;
    do_reset();
    r = 8'd0; b = 1'b0; m = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) r = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) b = ~b;
      step(b, m, r);
      checks++;
      if (dut_out() !== exp_out()) begin
        errors++; $display("FAIL random cyc=%0d got %h want %h", i, dut_out(), exp_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_bounce();
    test_pause_resume();
    test_wrap_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_bar_animator.md
# led_bar_animator

Parametrised LED bar pattern engine for the board-level LED demo path. It drives an `LED_W`-bit LED bank with one of four step animations (fill, drain, bounce, fill-wrap) at a programmable step rate. A push button starts, pauses and resumes the animation. It supersedes the fixed 16-LED saturating fill bar and adds modes, rate control, pause/resume and status outputs.

## Interface
- `LED_W`, 16: LED count; legal range 2..64
- `DIV_W`, 8: width of the `rate` prescaler input
- `clk`  in  1: clock
- `rst`  in  1: reset, asynchronous, active-high
- `button`  in  1: start/pause/resume request; acted on at its rising edge only
- `mode`  in  2: 0 FILL, 1 DRAIN, 2 BOUNCE, 3 FILL_WRAP; latched at start
- `rate`  in  DIV_W: one step every `rate+1` cycles; sampled live
- `led`  out  LED_W: registered LED pattern
- `busy`  out  1: high in RUN or PAUSE
- `paused`  out  1: high in PAUSE
- `done`  out  1: high in DONE

## Operation
- Edge detect: `btn_edge = button & ~button_q`. `button_q` is a register. A held button produces exactly one edge.
- FSM states: IDLE, RUN, PAUSE, DONE. Reset state is IDLE.
  - IDLE on `btn_edge`: go to RUN. Latch `mode`, clear the prescaler, load the initial pattern.
  - RUN on `btn_edge`: go to PAUSE.
  - PAUSE on `btn_edge`: go to RUN.
  - RUN to DONE when FILL or DRAIN reaches its terminal pattern.
  - DONE on `btn_edge`: restart exactly as from IDLE, latching the current `mode`.
- Initial patterns:
  - FILL: 0.
  - DRAIN: all ones.
  - BOUNCE: bit 0 set.
  - FILL_WRAP: 0.
- Level counter `lvl` is 0..LED_W, width `$clog2(LED_W+1)`. Position `pos` is 0..LED_W-1, with direction bit `dir` (0 = up).
- Per tick in RUN:
  - FILL: `lvl+1`, `led = (1<<lvl)-1`. At `lvl==LED_W` (all ones), go to DONE.
  - DRAIN: `lvl+1`, `led` = the low `LED_W-lvl` bits set. At `lvl==LED_W` (zero), go to DONE.
  - BOUNCE: single hot bit moves 0→LED_W-1→0 and repeats. Reversal happens without dwelling, so the end bits are lit for one step each. Never reaches DONE.
  - FILL_WRAP: as FILL, but the tick after all-ones gives `led=0` and `lvl=0`. Never reaches DONE.
- Prescaler:
  - In RUN, it counts 0..`rate` and ticks when `cnt==rate`, then returns to 0.
  - `rate=0` gives a tick every cycle.
  - If `rate` is lowered below the current `cnt`, the count wraps through its maximum and continues.
  - The count holds in PAUSE, IDLE and DONE.
- `mode` changes after start are ignored until the next start.
- `led` holds its value in PAUSE and DONE. `led` is 0 in IDLE.

## Timing
- Reset values: `led=0`, `busy=0`, `paused=0`, `done=0`, `button_q=0`, all counters 0.
- `rst` mid-operation clears all state immediately, with no clock needed.
- Start: at the first clk edge where `btn_edge=1`, the state becomes RUN and `led` shows the initial pattern.
- First step lands `rate+1` edges after the start edge.
- On the final FILL/DRAIN step, `done` rises on the same edge that `led` shows the terminal pattern.
- If `btn_edge` coincides with a tick in RUN, pause wins and no step is taken.
- On resume, the prescaler continues from its held count.
- Status outputs are registered and track the state, with no extra latency.

## Configuration
- `LED_BAR_BTN_SYNC_EN` defined:
  - `button` passes through a 2-flop synchroniser before edge detection.
  - All button-driven transitions occur 2 cycles later than listed above.
  - Synchroniser flops reset to 0.
- `LED_BAR_BTN_SYNC_EN` undefined: `button` feeds edge detection directly. Use this only when `button` is already synchronous to `clk`.

## Structure
- Package `led_bar_pkg`:
  - mode enum `led_mode_t` (FILL, DRAIN, BOUNCE, FILL_WRAP)
  - state enum `led_state_t` (IDLE, RUN, PAUSE, DONE)
  - constants for mode encodings
- Sub-module `led_bar_prescaler`, ports `clk`, `rst`, `en`, `clr`, `rate`, `tick`. It is instantiated once.
- Pattern generation and the FSM live in the top module.

## Test plan
All scenarios use `LED_W=16` and `LED_BAR_BTN_SYNC_EN` undefined.
- Reset, then no button: `led=0x0000`, `busy=0`, `done=0` held for 20 cycles.
- FILL, `rate=0`, button pulse at edge t:
  - `led=0x0000` at t, `0x0001` at t+1, `0x0003` at t+2.
  - `0xFFFF` with `done=1` at t+16; holds thereafter.
- DRAIN, `rate=3`:
  - `led` goes 0xFFFF→0x7FFF at start+4, then 0x3FFF at start+8.
  - `0x0000` with `done=1` at start+64.
- BOUNCE, `rate=0`:
  - `0x0001`…`0x8000` at start+15, `0x4000` at start+16, `0x0001` at start+30.
  - `done` stays 0 for 200 cycles.
- Pause/resume, FILL, `rate=0`:
  - Button edge while `led=0x00FF`: `led` holds 0x00FF and `paused=1` for 10 cycles.
  - Second edge: `0x01FF` on the next edge.
  - A held button never causes a second toggle.
- FILL_WRAP, then async reset:
  - `0xFFFF` is followed by `0x0000`, then `0x0001`.
  - Changing `mode` to DRAIN mid-run has no effect.
  - Asserting `rst` mid-cycle drives `led=0` and `busy=0` immediately.
